spi_adc_slave: RTL and testbench
================================

Name: spi_adc_slave

Overview:
- Serial-ADC responder model/emulator for the far end of the ADC serial link.
- Watches the master's cs and sclk, oversampling them on the 50 MHz system clock.
- For each cs-low frame, shifts out LEAD_ZEROS zero bits followed by a DATA_W-bit sample, MSB first, on sdo.
- Used as the device-side counterpart of the sclk/cs generator, both in loopback benches and in FPGA self-test.

Parameters:
DATA_W, 12, sample width in bits
LEAD_ZEROS, 4, zero bits sent before the sample MSB
FRAME_W, DATA_W+LEAD_ZEROS (16), bits per frame (derived, not overridable)

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
cs  input  1  frame select from master, active low, asynchronous to clk
sclk  input  1  serial clock from master, idles high, asynchronous to clk
sample  input  DATA_W  next conversion value
sample_vld  input  1  loads sample into the holding register
sdo  output  1  serial data to master
sdo_oe  output  1  drive enable for sdo (1 = driving)
busy  output  1  frame in progress (SHIFT or DONE)
frame_done  output  1  one-clk pulse when all FRAME_W bits have been sampled by the master
frame_err  output  1  one-clk pulse when cs rises before the frame completes

Behaviour:
- Reset: all outputs 0; hold_q=0; shreg=0; bit_cnt=0; state=IDLE. cs and sclk synchroniser and edge flops reset to 1.
- Input sync: 2-flop synchroniser plus one history flop per input. An edge is detected 2-3 clk after the pin toggles.
- Edge detection:
  - cs_fall/cs_rise from the synchronised cs.
  - sclk_rise/sclk_fall from the synchronised sclk.
  - Master must hold each sclk phase ≥3 clk.
- Holding register:
  - hold_q <= sample whenever sample_vld=1, in any state.
  - If sample_vld and cs_fall occur in the same cycle, the frame uses the new sample (bypass).
- States:
  - IDLE:
    - sdo_oe=0, sdo=0, busy=0.
    - On cs_fall: shreg <= {LEAD_ZEROS'b0, hold_or_bypass}, bit_cnt <= 0, go to SHIFT.
    - sclk edges are ignored.
  - SHIFT:
    - sdo_oe=1, busy=1, sdo=shreg[FRAME_W-1]; the first bit is valid from SHIFT entry.
    - On sclk_rise: bit_cnt+1.
    - On sclk_fall: shreg shifts left by 1, zero fill. This happens only while bit_cnt<FRAME_W.
    - When bit_cnt reaches FRAME_W (on the FRAME_W-th rise): go to DONE; frame_done=1 for exactly that cycle.
    - On cs_rise: go to IDLE and pulse frame_err; sdo_oe=0 the next cycle.
  - DONE:
    - sdo_oe=1, sdo=0, busy=1.
    - Extra sclk edges are ignored; no further frame_done.
    - On cs_rise: go to IDLE; no error.
- Simultaneous events:
  - cs_rise in the same cycle as any sclk edge: cs_rise wins and the sclk edge is discarded.
  - In SHIFT, a cs_rise coinciding with the FRAME_W-th sclk_rise counts as complete: frame_done=1, frame_err=0, next state IDLE.
- Back-to-back frames: cs_fall is only acted on in IDLE. A cs low→high→low sequence yields two frames, each reloading from hold_q.
- Reset asserted mid-frame: immediate return to IDLE values.
- Reset release with cs already low: the cs sync flops reset to 1, so a cs_fall is detected ~3 clk after release and a fresh frame starts using hold_q=0.
- bit_cnt width: clog2(FRAME_W+1). It saturates at FRAME_W and never wraps.

Test Plan:
- sample=12'hA5C, pulse sample_vld, then cs low with 16 sclk periods (8 clk low/8 clk high) → master samples 0000_1010_0101_1100 on rising edges; frame_done pulses once after 16th rise; sdo_oe=1 from cs_fall+3 clk until cs_rise+3 clk.
- Same setup, cs raised after 8 sclk rises → frame_err single pulse; frame_done stays 0; sdo_oe=0 and busy=0 within 4 clk of cs rise.
- hold_q=12'h123, sample_vld with sample=12'hFFF in the same clk as cs_fall detection → frame shifts 0000_1111_1111_1111.
- 20 sclk periods in one frame with sample=12'hFFF → bits 17-20 read 0; frame_done pulses exactly once.
- rst_n pulsed low mid-frame at bit 6, cs held low through release → outputs 0 during reset; new frame starts ~3 clk after release and shifts 16 zeros.
- Two back-to-back frames, sample 12'h001 then 12'h800, cs high 5 clk between them → both frames correct; two frame_done pulses; no frame_err.

Source files
------------

// File: rtl/spi_adc_slave_if.sv
// Serial ADC link bundle: the master's cs/sclk plus the sample feed, and the device's sdo and frame status.
interface spi_adc_slave_if #(
  parameter int DATA_W = 12
);
  logic              cs;
  logic              sclk;
  logic [DATA_W-1:0] sample;
  logic              sample_vld;
  logic              sdo;
  logic              sdo_oe;
  logic              busy;
  logic              frame_done;
  logic              frame_err;

  modport master (
    output cs, sclk, sample, sample_vld,
    input  sdo, sdo_oe, busy, frame_done, frame_err
  );

  modport slave (
    input  cs, sclk, sample, sample_vld,
    output sdo, sdo_oe, busy, frame_done, frame_err
  );
endinterface

// File: rtl/spi_adc_slave.sv
// Device-side serial ADC emulator: oversamples cs/sclk on clk and shifts out
// LEAD_ZEROS zeros then a DATA_W-bit sample, MSB first, once per cs-low frame.
module spi_adc_slave #(
  parameter int DATA_W     = 12,
  parameter int LEAD_ZEROS = 4
) (
  input logic            clk,
  input logic            rst_n,
  spi_adc_slave_if.slave bus
);
  localparam int FRAME_W = DATA_W + LEAD_ZEROS;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  // Two metastability flops plus one history flop per pin; all idle high.
  logic cs_m_q, cs_s_q, cs_h_q;
  logic sclk_m_q, sclk_s_q, sclk_h_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_m_q   <= 1'b1;
      cs_s_q   <= 1'b1;
      cs_h_q   <= 1'b1;
      sclk_m_q <= 1'b1;
      sclk_s_q <= 1'b1;
      sclk_h_q <= 1'b1;
    end else begin
      cs_m_q   <= bus.cs;
      cs_s_q   <= cs_m_q;
      cs_h_q   <= cs_s_q;
      sclk_m_q <= bus.sclk;
      sclk_s_q <= sclk_m_q;
      sclk_h_q <= sclk_s_q;
    end
  end

  logic cs_fall, cs_rise, sclk_rise, sclk_fall;
  assign cs_fall   =  cs_h_q   & ~cs_s_q;
  assign cs_rise   = ~cs_h_q   &  cs_s_q;
  assign sclk_fall =  sclk_h_q & ~sclk_s_q;
  assign sclk_rise = ~sclk_h_q &  sclk_s_q;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_err_q, frame_err_d;
  logic [DATA_W-1:0]  load_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // A sample arriving in the cs_fall cycle bypasses the holding register.
  assign load_val = bus.sample_vld ? bus.sample : hold_q;

  always_comb begin
    state_d      = state_q;
    hold_d       = bus.sample_vld ? bus.sample : hold_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          shreg_d   = {{LEAD_ZEROS{1'b0}}, load_val};
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          // cs_rise wins over sclk, except it still completes a frame on its last rise.
          if (sclk_rise && bit_cnt_q == LAST_BIT) begin
            frame_done_d = 1'b1;
            bit_cnt_d    = FULL_CNT;
          end else begin
            frame_err_d  = 1'b1;
          end
          state_d = IDLE;
        end else if (sclk_rise && bit_cnt_q != FULL_CNT) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            frame_done_d = 1'b1;
            state_d      = DONE;
          end
        end else if (sclk_fall && bit_cnt_q < FULL_CNT) begin
          shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
        end
      end
      DONE: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sdo        = (state_q == SHIFT) & shreg_q[FRAME_W-1];
  assign bus.sdo_oe     = (state_q != IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_spi_adc_slave.sv
// Directed bench for spi_adc_slave: drives cs/sclk frames like the master and checks the shifted bits and status.
module tb_spi_adc_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  spi_adc_slave_if #(.DATA_W(12)) bus();
  spi_adc_slave #(.DATA_W(12), .LEAD_ZEROS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int checks = 0;
  int passed = 0;
  int fd_cnt = 0;
  int fe_cnt = 0;
  int fd0, fe0;
  logic [31:0] bits;

  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) fd_cnt++;
    if (bus.frame_err === 1'b1) fe_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [11:0] v);
    bus.sample = v;
    bus.sample_vld = 1'b1;
    tick();
    bus.sample_vld = 1'b0;
    tick();
  endtask

  // cs and sclk drop together, so the first low phase is absorbed by the frame start.
  task automatic start_frame();
    bus.cs = 1'b0;
    bus.sclk = 1'b0;
    repeat (8) tick();
  endtask

  task automatic clock_bits(input int n, input bit lead_fall, output logic [31:0] b);
    b = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0 || lead_fall) begin
        bus.sclk = 1'b0;
        repeat (8) tick();
      end
      b = {b[30:0], bus.sdo};
      bus.sclk = 1'b1;
      repeat (8) tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cs = 1'b1;
    bus.sclk = 1'b1;
    bus.sample = '0;
    bus.sample_vld = 1'b0;
    repeat (3) tick();
    check("reset_sdo_oe", 32'(bus.sdo_oe), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_sdo", 32'(bus.sdo), 32'd0);
    check("reset_pulses", {30'd0, bus.frame_done, bus.frame_err}, 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Full frame of 12'hA5C
    load(12'hA5C);
    fd0 = fd_cnt; fe0 = fe_cnt;
    bus.cs = 1'b0; bus.sclk = 1'b0;
    tick(); tick();
    check("t1_oe_before", 32'(bus.sdo_oe), 32'd0);
    tick();
    check("t1_oe_at3", 32'(bus.sdo_oe), 32'd1);
    check("t1_first_bit", 32'(bus.sdo), 32'd0);
    repeat (5) tick();
    clock_bits(16, 1'b0, bits);
    check("t1_bits", bits, 32'h0000_0A5C);
    check("t1_done_cnt", 32'(fd_cnt - fd0), 32'd1);
    bus.cs = 1'b1;
    tick(); tick();
    check("t1_oe_hold", 32'(bus.sdo_oe), 32'd1);
    tick();
    check("t1_oe_off", 32'(bus.sdo_oe), 32'd0);
    tick();
    check("t1_err_cnt", 32'(fe_cnt - fe0), 32'd0);

    // Aborted frame after 8 rises
    fd0 = fd_cnt; fe0 = fe_cnt;
    start_frame();
    clock_bits(8, 1'b0, bits);
    check("t2_bits", bits, 32'h0000_000A);
    bus.cs = 1'b1;
    repeat (4) tick();
    check("t2_busy", 32'(bus.busy), 32'd0);
    check("t2_oe", 32'(bus.sdo_oe), 32'd0);
    tick();
    check("t2_err_cnt", 32'(fe_cnt - fe0), 32'd1);
    check("t2_done_cnt", 32'(fd_cnt - fd0), 32'd0);

    // Bypass: sample_vld lands in the cs_fall detection cycle
    load(12'h123);
    fd0 = fd_cnt;
    bus.cs = 1'b0; bus.sclk = 1'b0;
    tick(); tick();
    bus.sample = 12'hFFF; bus.sample_vld = 1'b1;
    tick();
    bus.sample_vld = 1'b0;
    repeat (5) tick();
    clock_bits(16, 1'b0, bits);
    check("t3_bits", bits, 32'h0000_0FFF);
    bus.cs = 1'b1;
    repeat (5) tick();

    // 20 sclk periods with 12'hFFF
    fd0 = fd_cnt; fe0 = fe_cnt;
    start_frame();
    clock_bits(20, 1'b0, bits);
    check("t4_bits", bits, 32'h000_0FFF0);
    bus.cs = 1'b1;
    repeat (5) tick();
    check("t4_done_cnt", 32'(fd_cnt - fd0), 32'd1);
    check("t4_err_cnt", 32'(fe_cnt - fe0), 32'd0);

    // Reset mid-frame at bit 6 with cs held low
    load(12'hA5C);
    start_frame();
    clock_bits(6, 1'b0, bits);
    rst_n = 1'b0;
    #1;
    check("t5_rst_oe", 32'(bus.sdo_oe), 32'd0);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    tick(); tick();
    check("t5_rst_out", {28'd0, bus.sdo, bus.sdo_oe, bus.frame_done, bus.frame_err}, 32'd0);
    rst_n = 1'b1;
    fd0 = fd_cnt; fe0 = fe_cnt;
    tick(); tick();
    check("t5_busy_pre", 32'(bus.busy), 32'd0);
    tick();
    check("t5_busy_restart", 32'(bus.busy), 32'd1);
    repeat (2) tick();
    clock_bits(16, 1'b1, bits);
    check("t5_bits", bits, 32'h0000_0000);
    bus.cs = 1'b1;
    repeat (5) tick();
    check("t5_done_cnt", 32'(fd_cnt - fd0), 32'd1);

    // Back-to-back frames 12'h001 then 12'h800
    load(12'h001);
    fd0 = fd_cnt; fe0 = fe_cnt;
    start_frame();
    clock_bits(16, 1'b0, bits);
    check("t6_bits_a", bits, 32'h0000_0001);
    bus.cs = 1'b1;
    tick(); tick();
    bus.sample = 12'h800; bus.sample_vld = 1'b1;
    tick();
    bus.sample_vld = 1'b0;
    tick(); tick();
    start_frame();
    clock_bits(16, 1'b0, bits);
    check("t6_bits_b", bits, 32'h0000_0800);
    bus.cs = 1'b1;
    repeat (5) tick();
    check("t6_done_cnt", 32'(fd_cnt - fd0), 32'd2);
    check("t6_err_cnt", 32'(fe_cnt - fe0), 32'd0);
    check("t6_idle", {30'd0, bus.busy, bus.sdo_oe}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
